unidade_controle_multiciclo: RTL and testbench
==============================================

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, named as below.
REQ-002 The port list SHALL be:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- instrucao  in  32  current instruction register contents
- ula_zero  in  1  1 when the ALU resultado equals 32'h0
- mem_pronto  in  1  memory completed the requested read or write this cycle
- operacao_ula  out  4  0000 SOMA, 0001 SUBTRACAO, 0010 AND, 0011 OR, 0100 SRL
- sel_ula_a  out  2  00 PC, 01 rs1, 10 PC_antigo
- sel_ula_b  out  2  00 rs2, 01 constant 4, 10 immediate
- sel_pc  out  1  0 live ALU result, 1 registered ALU output
- sel_endereco  out  1  0 PC, 1 registered ALU output
- sel_escrita_reg  out  1  0 registered ALU output, 1 memory data
- pc_escreve, ir_escreve, reg_escreve, mem_le, mem_escreve  out  1 each  write and access strobes
- estado  out  3  current FSM state
- instr_invalida  out  1  sticky unsupported-instruction flag

Function
REQ-003 States SHALL be BUSCA=000, DECODIFICA=001, EXECUTA=010, MEMORIA=011, ESCRITA=100, ERRO=101; unused codes SHALL go to ERRO.
REQ-004 BUSCA: mem_le=1, sel_endereco=0, ula PC+4 (sel_ula_a=00, sel_ula_b=01, SOMA). The state SHALL hold while mem_pronto=0. On mem_pronto=1: ir_escreve=1, pc_escreve=1, sel_pc=0, then go to DECODIFICA.
REQ-005 DECODIFICA: ula PC_antigo+imm (10,10,SOMA) to precompute the branch target. Supported opcodes go to EXECUTA; others go to ERRO.
REQ-006 Supported instructions:
- lh: opcode 0000011, f3 001
- sh: opcode 0100011, f3 001
- sub: opcode 0110011, f3 000, f7 0100000
- or: opcode 0110011, f3 110, f7 0000000
- srl: opcode 0110011, f3 101, f7 0000000
- andi: opcode 0010011, f3 111
- beq: opcode 1100011, f3 000
Any other opcode, funct3 or funct7 SHALL be invalid.
REQ-007 EXECUTA behaviour per instruction:
- lh/sh: rs1+imm (01,10,SOMA), then MEMORIA
- sub/or/srl: rs1 op rs2 (01,00, SUBTRACAO/OR/SRL), then ESCRITA
- andi: rs1&imm (01,10,AND), then ESCRITA
- beq: rs1-rs2 (01,00,SUBTRACAO); pc_escreve=ula_zero with sel_pc=1 in the same cycle, then BUSCA
REQ-008 MEMORIA: sel_endereco=1 and the state SHALL hold while mem_pronto=0.
- lh: mem_le=1; on mem_pronto=1 go to ESCRITA
- sh: mem_escreve=1; on mem_pronto=1 go to BUSCA
REQ-009 ESCRITA: reg_escreve=1 for exactly one cycle, sel_escrita_reg=1 for lh and 0 otherwise, then BUSCA.
REQ-010 ERRO: instr_invalida=1 and all strobes 0; the FSM SHALL stay in ERRO until reset.
REQ-011 Outputs not named for a state SHALL be 0, with operacao_ula=0000.
REQ-012 Latency with zero memory wait SHALL be: beq 3, sh 4, R-type/andi 4, lh 5 cycles. Each mem_pronto=0 cycle SHALL add one cycle.
REQ-013 At most one of mem_le/mem_escreve SHALL be asserted in any cycle. mem_pronto outside BUSCA/MEMORIA SHALL be ignored.

Reset
REQ-014 rst_n=0 SHALL immediately force estado=BUSCA, all strobes 0, all selects 0, operacao_ula=0000 and instr_invalida=0, independent of clk.
REQ-015 Reset during a memory wait SHALL abandon the access with no write strobe. The first fetch SHALL start on the first rising edge after rst_n rises.

Configuration
REQ-016 With CONTADOR_INSTR_EN defined, the block SHALL add output instr_concluidas[31:0]: reset to 0, +1 on each return to BUSCA after a completed instruction, wrapping 0xFFFFFFFF to 0. Without the macro the port and its logic SHALL be absent.

Verification
REQ-017 The bench SHALL cover:
- sub (0x40208233), mem_pronto always 1 -> estados 0,1,2,4,0; reg_escreve=1 only in cycle 4; operacao_ula=0001 in EXECUTA.
- lh with mem_pronto low for 2 MEMORIA cycles -> MEMORIA lasts 3 cycles with mem_le=1, then ESCRITA with sel_escrita_reg=1; 7 cycles total.
- beq, ula_zero=1 then ula_zero=0 -> pc_escreve=1 with sel_pc=1 in EXECUTA only when taken; 3 cycles each.
- Opcode 0110111 -> ERRO after DECODIFICA; instr_invalida=1 persists 10 cycles until rst_n=0.
- rst_n=0 asserted mid-MEMORIA of sh -> mem_escreve drops before the next edge; estado=000.
- With CONTADOR_INSTR_EN, 3 instructions -> instr_concluidas=3; preload 0xFFFFFFFF, one more instruction -> 0.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit for a small RV32 subset (lh, sh, sub, or, srl, andi, beq).
// Optional build macro CONTADOR_INSTR_EN adds the instr_concluidas retired-instruction counter.
module unidade_controle_multiciclo (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instrucao,
   input  logic        ula_zero,
   input  logic        mem_pronto,
   output logic [3:0]  operacao_ula,
   output logic [1:0]  sel_ula_a,
   output logic [1:0]  sel_ula_b,
   output logic        sel_pc,
   output logic        sel_endereco,
   output logic        sel_escrita_reg,
   output logic        pc_escreve,
   output logic        ir_escreve,
   output logic        reg_escreve,
   output logic        mem_le,
   output logic        mem_escreve,
   output logic [2:0]  estado,
   output logic        instr_invalida
`ifdef CONTADOR_INSTR_EN
   ,
   output logic [31:0] instr_concluidas
`endif
);

   typedef enum logic [2:0] {
      BUSCA      = 3'b000,
      DECODIFICA = 3'b001,
      EXECUTA    = 3'b010,
      MEMORIA    = 3'b011,
      ESCRITA    = 3'b100,
      ERRO       = 3'b101
   } estado_t;

   typedef enum logic [2:0] {
      I_LH, I_SH, I_SUB, I_OR, I_SRL, I_ANDI, I_BEQ, I_NONE
   } instr_t;

   localparam logic [3:0] OP_SOMA = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;

   estado_t     estado_q, estado_d;
   instr_t      instr;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        unused_campos;

   assign opcode        = instrucao[6:0];
   assign f3            = instrucao[14:12];
   assign f7            = instrucao[31:25];
   assign unused_campos = ^{instrucao[24:15], instrucao[11:7]};

   // IR is stable from DECODIFICA onward, so decoding it combinationally is safe.
   always_comb begin
      instr = I_NONE;
      case (opcode)
         7'b0000011: if (f3 == 3'b001) instr = I_LH;
         7'b0100011: if (f3 == 3'b001) instr = I_SH;
         7'b0010011: if (f3 == 3'b111) instr = I_ANDI;
         7'b1100011: if (f3 == 3'b000) instr = I_BEQ;
         7'b0110011: begin
            if      (f3 == 3'b000 && f7 == 7'b0100000) instr = I_SUB;
            else if (f3 == 3'b110 && f7 == 7'b0000000) instr = I_OR;
            else if (f3 == 3'b101 && f7 == 7'b0000000) instr = I_SRL;
         end
         default: instr = I_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado_q <= BUSCA;
      else        estado_q <= estado_d;
   end

   assign estado = estado_q;

   // Outputs are gated by rst_n so that reset clears them without waiting for a clock.
   always_comb begin
      estado_d        = estado_q;
      operacao_ula    = OP_SOMA;
      sel_ula_a       = 2'b00;
      sel_ula_b       = 2'b00;
      sel_pc          = 1'b0;
      sel_endereco    = 1'b0;
      sel_escrita_reg = 1'b0;
      pc_escreve      = 1'b0;
      ir_escreve      = 1'b0;
      reg_escreve     = 1'b0;
      mem_le          = 1'b0;
      mem_escreve     = 1'b0;
      instr_invalida  = 1'b0;
      if (rst_n) begin
         case (estado_q)
            BUSCA: begin
               mem_le    = 1'b1;
               sel_ula_b = 2'b01;
               if (mem_pronto) begin
                  ir_escreve = 1'b1;
                  pc_escreve = 1'b1;
                  estado_d   = DECODIFICA;
               end
            end
            DECODIFICA: begin
               sel_ula_a = 2'b10;
               sel_ula_b = 2'b10;
               estado_d  = (instr == I_NONE) ? ERRO : EXECUTA;
            end
            EXECUTA: begin
               sel_ula_a = 2'b01;
               case (instr)
                  I_LH, I_SH: begin
                     sel_ula_b = 2'b10;
                     estado_d  = MEMORIA;
                  end
                  I_SUB: begin operacao_ula = OP_SUB; estado_d = ESCRITA; end
                  I_OR:  begin operacao_ula = OP_OR;  estado_d = ESCRITA; end
                  I_SRL: begin operacao_ula = OP_SRL; estado_d = ESCRITA; end
                  I_ANDI: begin
                     sel_ula_b    = 2'b10;
                     operacao_ula = OP_AND;
                     estado_d     = ESCRITA;
                  end
                  I_BEQ: begin
                     operacao_ula = OP_SUB;
                     sel_pc       = 1'b1;
                     pc_escreve   = ula_zero;
                     estado_d     = BUSCA;
                  end
                  default: estado_d = ERRO;
               endcase
            end
            MEMORIA: begin
               sel_endereco = 1'b1;
               if (instr == I_LH) begin
                  mem_le = 1'b1;
                  if (mem_pronto) estado_d = ESCRITA;
               end else if (instr == I_SH) begin
                  mem_escreve = 1'b1;
                  if (mem_pronto) estado_d = BUSCA;
               end else begin
                  estado_d = ERRO;
               end
            end
            ESCRITA: begin
               reg_escreve     = 1'b1;
               sel_escrita_reg = (instr == I_LH);
               estado_d        = BUSCA;
            end
            ERRO: begin
               instr_invalida = 1'b1;
               estado_d       = ERRO;
            end
            default: estado_d = ERRO;
         endcase
      end
   end

`ifdef CONTADOR_INSTR_EN
   logic concluiu;
   // Only EXECUTA (beq), MEMORIA (sh) and ESCRITA can return to BUSCA.
   assign concluiu = (estado_d == BUSCA) && (estado_q != BUSCA) && (estado_q != ERRO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        instr_concluidas <= 32'd0;
      else if (concluiu) instr_concluidas <= instr_concluidas + 32'd1;
   end
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed, table-driven bench for unidade_controle_multiciclo.
module tb_unidade_controle_multiciclo;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instrucao = 32'h0;
   logic        ula_zero = 1'b0;
   logic        mem_pronto = 1'b0;
   logic [3:0]  operacao_ula;
   logic [1:0]  sel_ula_a, sel_ula_b;
   logic        sel_pc, sel_endereco, sel_escrita_reg;
   logic        pc_escreve, ir_escreve, reg_escreve, mem_le, mem_escreve;
   logic [2:0]  estado;
   logic        instr_invalida;
`ifdef CONTADOR_INSTR_EN
   logic [31:0] instr_concluidas;
`endif

   int total = 0;
   int bad = 0;

   unidade_controle_multiciclo dut (
      .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .ula_zero(ula_zero),
      .mem_pronto(mem_pronto), .operacao_ula(operacao_ula), .sel_ula_a(sel_ula_a),
      .sel_ula_b(sel_ula_b), .sel_pc(sel_pc), .sel_endereco(sel_endereco),
      .sel_escrita_reg(sel_escrita_reg), .pc_escreve(pc_escreve), .ir_escreve(ir_escreve),
      .reg_escreve(reg_escreve), .mem_le(mem_le), .mem_escreve(mem_escreve),
      .estado(estado), .instr_invalida(instr_invalida)
`ifdef CONTADOR_INSTR_EN
      , .instr_concluidas(instr_concluidas)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [31:0] SUB  = 32'h40208233;
   localparam logic [31:0] LH   = 32'h00409283;
   localparam logic [31:0] SH   = 32'h00209223;
   localparam logic [31:0] BEQ  = 32'h00208463;
   localparam logic [31:0] OR_  = 32'h0020e233;
   localparam logic [31:0] SRL  = 32'h0020d233;
   localparam logic [31:0] ANDI = 32'h0ff0f213;
   localparam logic [31:0] LUI  = 32'h000012b7;
   localparam logic [31:0] ADD  = 32'h00208233;

   // {op, sel_a, sel_b, {sel_pc,sel_end,sel_esc}, {pc_w,ir_w,reg_w,le,es}, estado, inv}
   function automatic logic [19:0] ex(input logic [3:0] op, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] sel,
                                      input logic [4:0] str, input logic [2:0] st,
                                      input logic inv);
      return {op, sa, sb, sel, str, st, inv};
   endfunction

   localparam logic [19:0] ZERO = 20'h0;
   logic [19:0] B_WAIT, B_OK, DEC, E_SUB, E_OR, E_SRL, E_ANDI, E_MEM, E_BEQ_T, E_BEQ_N;
   logic [19:0] M_LH, M_SH, W_LH, W_ALU, ERR;

   typedef struct {
      logic [31:0] ins;
      logic        z;
      logic        p;
      logic [19:0] exp;
   } vec_t;
   vec_t tab[$];

   function automatic logic [19:0] got();
      return {operacao_ula, sel_ula_a, sel_ula_b, sel_pc, sel_endereco, sel_escrita_reg,
              pc_escreve, ir_escreve, reg_escreve, mem_le, mem_escreve, estado, instr_invalida};
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   // Called at a negedge: drive, check mid-cycle, then wait to the next negedge.
   task automatic vec(input string nm, input logic [31:0] ins, input logic z,
                      input logic p, input logic [19:0] e);
      instrucao  = ins;
      ula_zero   = z;
      mem_pronto = p;
      #1;
      chk(nm, {12'h0, got()}, {12'h0, e});
      @(negedge clk);
   endtask

   task automatic add(input logic [31:0] ins, input logic z, input logic p, input logic [19:0] e);
      tab.push_back('{ins, z, p, e});
   endtask

   initial begin
      B_WAIT  = ex(4'd0, 2'b00, 2'b01, 3'b000, 5'b00010, 3'd0, 1'b0);
      B_OK    = ex(4'd0, 2'b00, 2'b01, 3'b000, 5'b11010, 3'd0, 1'b0);
      DEC     = ex(4'd0, 2'b10, 2'b10, 3'b000, 5'b00000, 3'd1, 1'b0);
      E_SUB   = ex(4'd1, 2'b01, 2'b00, 3'b000, 5'b00000, 3'd2, 1'b0);
      E_OR    = ex(4'd3, 2'b01, 2'b00, 3'b000, 5'b00000, 3'd2, 1'b0);
      E_SRL   = ex(4'd4, 2'b01, 2'b00, 3'b000, 5'b00000, 3'd2, 1'b0);
      E_ANDI  = ex(4'd2, 2'b01, 2'b10, 3'b000, 5'b00000, 3'd2, 1'b0);
      E_MEM   = ex(4'd0, 2'b01, 2'b10, 3'b000, 5'b00000, 3'd2, 1'b0);
      E_BEQ_T = ex(4'd1, 2'b01, 2'b00, 3'b100, 5'b10000, 3'd2, 1'b0);
      E_BEQ_N = ex(4'd1, 2'b01, 2'b00, 3'b100, 5'b00000, 3'd2, 1'b0);
      M_LH    = ex(4'd0, 2'b00, 2'b00, 3'b010, 5'b00010, 3'd3, 1'b0);
      M_SH    = ex(4'd0, 2'b00, 2'b00, 3'b010, 5'b00001, 3'd3, 1'b0);
      W_LH    = ex(4'd0, 2'b00, 2'b00, 3'b001, 5'b00100, 3'd4, 1'b0);
      W_ALU   = ex(4'd0, 2'b00, 2'b00, 3'b000, 5'b00100, 3'd4, 1'b0);
      ERR     = ex(4'd0, 2'b00, 2'b00, 3'b000, 5'b00000, 3'd5, 1'b1);

      // sub: 4 cycles, reg_escreve only in the 4th
      add(SUB, 0, 1, B_OK);  add(SUB, 0, 1, DEC);  add(SUB, 0, 1, E_SUB); add(SUB, 0, 1, W_ALU);
      // lh with two wait cycles in MEMORIA: 7 cycles
      add(LH, 0, 1, B_OK);   add(LH, 0, 1, DEC);   add(LH, 0, 1, E_MEM);
      add(LH, 0, 0, M_LH);   add(LH, 0, 0, M_LH);  add(LH, 0, 1, M_LH);  add(LH, 0, 1, W_LH);
      // beq taken, then not taken
      add(BEQ, 1, 1, B_OK);  add(BEQ, 1, 1, DEC);  add(BEQ, 1, 1, E_BEQ_T);
      add(BEQ, 0, 1, B_OK);  add(BEQ, 0, 1, DEC);  add(BEQ, 0, 1, E_BEQ_N);
      // sh with a fetch wait; mem_pronto high in EXECUTA must be ignored
      add(SH, 0, 0, B_WAIT); add(SH, 0, 1, B_OK);  add(SH, 0, 1, DEC);
      add(SH, 0, 1, E_MEM);  add(SH, 0, 1, M_SH);
      add(OR_, 0, 1, B_OK);  add(OR_, 0, 1, DEC);  add(OR_, 0, 1, E_OR);  add(OR_, 0, 1, W_ALU);
      add(SRL, 0, 1, B_OK);  add(SRL, 0, 1, DEC);  add(SRL, 0, 1, E_SRL); add(SRL, 0, 1, W_ALU);
      add(ANDI, 0, 1, B_OK); add(ANDI, 0, 1, DEC); add(ANDI, 0, 1, E_ANDI); add(ANDI, 0, 1, W_ALU);
      add(SUB, 0, 0, B_WAIT);

      #2;
      chk("reset_state", {12'h0, got()}, {12'h0, ZERO});
      @(negedge clk);
      rst_n = 1'b1;
      foreach (tab[i]) vec($sformatf("row%0d", i), tab[i].ins, tab[i].z, tab[i].p, tab[i].exp);

      // unsupported opcode: sticky ERRO until reset
      rst_n = 1'b0; #1; rst_n = 1'b1;
      vec("lui_busca", LUI, 0, 1, B_OK);
      vec("lui_dec", LUI, 0, 1, DEC);
      for (int k = 0; k < 10; k++) vec($sformatf("lui_erro%0d", k), LUI, 0, 1, ERR);
      rst_n = 1'b0; #1;
      chk("erro_reset_async", {12'h0, got()}, {12'h0, ZERO});
      @(negedge clk);
      rst_n = 1'b1;

      // add (f7=0000000 with f3=000) is not supported
      vec("add_busca", ADD, 0, 1, B_OK);
      vec("add_dec", ADD, 0, 1, DEC);
      vec("add_erro", ADD, 0, 1, ERR);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;

      // reset mid-MEMORIA of sh abandons the store
      vec("sh_b", SH, 0, 1, B_OK);
      vec("sh_d", SH, 0, 1, DEC);
      vec("sh_e", SH, 0, 1, E_MEM);
      vec("sh_m_wait", SH, 0, 0, M_SH);
      #2; rst_n = 1'b0; #1;
      chk("sh_rst_mem_escreve", {31'h0, mem_escreve}, 32'h0);
      chk("sh_rst_estado", {29'h0, estado}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      vec("first_fetch", SUB, 0, 1, B_OK);
      vec("first_fetch_dec", SUB, 0, 1, DEC);

`ifdef CONTADOR_INSTR_EN
      rst_n = 1'b0; #1;
      chk("cnt_reset", instr_concluidas, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vec("cnt_b", BEQ, 0, 1, B_OK);
         vec("cnt_d", BEQ, 0, 1, DEC);
         vec("cnt_e", BEQ, 0, 1, E_BEQ_N);
      end
      chk("cnt_three", instr_concluidas, 32'd3);
      force dut.instr_concluidas = 32'hFFFFFFFF;
      #1;
      release dut.instr_concluidas;
      vec("cnt_w_b", BEQ, 0, 1, B_OK);
      vec("cnt_w_d", BEQ, 0, 1, DEC);
      vec("cnt_w_e", BEQ, 0, 1, E_BEQ_N);
      chk("cnt_wrap", instr_concluidas, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
